// File: rtl/scoreboard_reg_file_pkg.sv
// Purpose: shared sizing defaults and types for the scoreboard register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scoreboard_reg_file_pkg;

  localparam int M_DEFAULT = 3;                // register address width
  localparam int W_DEFAULT = 16;               // register data width
  localparam int N_DEFAULT = 1 << M_DEFAULT;   // register count

  // One busy bit per register, sized for the default configuration.
  typedef logic [N_DEFAULT-1:0] busy_vec_t;

endpackage

// File: rtl/scoreboard_reg_file_wdec.sv
// Purpose: one-hot decode of the writeback address, gated by the write enable.
// Latency: combinational.
// Backpressure: none; output is all-zero whenever en is low.
//
// Ports:
//   addr   - register address to decode
//   en     - decode enable; forces onehot to zero when low
//   onehot - N-bit one-hot enable, bit[addr] set when en is high
module regfile_wdec #(
  parameter int M = 3
) (
  input  logic [M-1:0]      addr,
  input  logic              en,
  output logic [(1<<M)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Purpose: register file with per-register busy scoreboard and two registered read ports.
// Latency: read data 1 cycle (write-first bypass); busy_a/busy_b combinational from current state.
// Backpressure: none; every write, issue and read is accepted each cycle.
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data - writeback: writes register and clears its busy bit
//   iss_en/iss_addr       - issue: sets busy bit of the destination register
//   rd_addr_a/rd_addr_b   - read addresses; rd_data_a/rd_data_b valid one cycle later
//   busy_a/busy_b         - busy bit of the current read addresses
//   busy_vec              - busy bit of every register
module scoreboard_reg_file
  import scoreboard_reg_file_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [M-1:0]        wr_addr,
  input  logic [W-1:0]        wr_data,
  input  logic                iss_en,
  input  logic [M-1:0]        iss_addr,
  input  logic [M-1:0]        rd_addr_a,
  input  logic [M-1:0]        rd_addr_b,
  output logic [W-1:0]        rd_data_a,
  output logic [W-1:0]        rd_data_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [(1<<M)-1:0]   busy_vec
);

  localparam int N = 1 << M;

  logic [N-1:0] wr_onehot;

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;
  logic [W-1:0] rd_data_a_q;
  logic [W-1:0] rd_data_a_d;
  logic [W-1:0] rd_data_b_q;
  logic [W-1:0] rd_data_b_d;

  regfile_wdec #(.M(M)) u_wdec (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // Register array next state; entry 0 is hardwired to zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_onehot[i]) begin
        regs_d[i] = wr_data;
      end
    end
    regs_d[0] = '0;
  end

  // Busy next state: writeback clears, issue sets afterwards so issue wins
  // when both target the same register.
  always_comb begin
    busy_d = busy_q & ~wr_onehot;
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Read ports with write-first bypass; address 0 always reads zero.
  always_comb begin
    rd_data_a_d = '0;
    if (rd_addr_a != '0) begin
      rd_data_a_d = wr_onehot[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
    end
    rd_data_b_d = '0;
    if (rd_addr_b != '0) begin
      rd_data_b_d = wr_onehot[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q      <= busy_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy_vec  = busy_q;
  assign busy_a    = busy_q[rd_addr_a];
  assign busy_b    = busy_q[rd_addr_b];

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Purpose: self-checking bench for scoreboard_reg_file (directed vectors plus reference model).
// Latency: model tracks the one-cycle read latency and write-first bypass.
// Backpressure: n/a.
module tb_scoreboard_reg_file;
  import scoreboard_reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic [7:0]  busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_reg_file #(.M(3), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_vec  (busy_vec)
  );

  // Reference model: plain array of register values plus a busy set.
  logic [15:0] m_regs [8];
  busy_vec_t   m_busy;
  logic [15:0] m_rd_a;
  logic [15:0] m_rd_b;
  bit          m_valid = 1'b0;

  function automatic logic [15:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_busy  = '0;
      m_rd_a  = 16'h0000;
      m_rd_b  = 16'h0000;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_rd_a = model_read(rd_addr_a);
      m_rd_b = model_read(rd_addr_b);
      if (wr_en && wr_addr != 3'd0) m_regs[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 3'd0) m_busy[iss_addr] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model; inputs change only just after
  // posedge, so negedge sees stable inputs and settled outputs.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model rd_data_a", {16'h0, rd_data_a}, {16'h0, m_rd_a});
      chk("model rd_data_b", {16'h0, rd_data_b}, {16'h0, m_rd_b});
      chk("model busy_vec",  {24'h0, busy_vec},  {24'h0, m_busy});
      chk("model busy_a",    {31'h0, busy_a},    {31'h0, m_busy[rd_addr_a]});
      chk("model busy_b",    {31'h0, busy_b},    {31'h0, m_busy[rd_addr_b]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    chk("reset rd_data_a", {16'h0, rd_data_a}, 32'h0);
    chk("reset rd_data_b", {16'h0, rd_data_b}, 32'h0);
    chk("reset busy_vec",  {24'h0, busy_vec},  32'h0);
    rst = 1'b0;

    // Read every address on both ports after reset.
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      tick();
      chk("post-reset read a", {16'h0, rd_data_a}, 32'h0);
      chk("post-reset read b", {16'h0, rd_data_b}, 32'h0);
    end
    chk("post-reset busy_vec", {24'h0, busy_vec}, 32'h0);

    // Write r5 then read it back.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr_a = 3'd0;
    tick();
    wr_en = 1'b0; rd_addr_a = 3'd5;
    tick();
    chk("r5 readback", {16'h0, rd_data_a}, 32'h0000BEEF);

    // Bypass on port B.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr_b = 3'd3;
    tick();
    chk("r3 bypass b", {16'h0, rd_data_b}, 32'h00001234);
    chk("r5 held a",   {16'h0, rd_data_a}, 32'h0000BEEF);

    // Writes to r0 are discarded, including via bypass.
    wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    tick();
    chk("r0 bypass a", {16'h0, rd_data_a}, 32'h0);
    chk("r0 bypass b", {16'h0, rd_data_b}, 32'h0);
    wr_en = 1'b0;
    tick();
    chk("r0 read a", {16'h0, rd_data_a}, 32'h0);
    chk("r0 read b", {16'h0, rd_data_b}, 32'h0);

    // Issue r6, then simultaneous write+issue r6, then write alone.
    iss_en = 1'b1; iss_addr = 3'd6; rd_addr_a = 3'd6;
    tick();
    chk("iss r6 busy_vec", {24'h0, busy_vec}, 32'h40);
    chk("iss r6 busy_a",   {31'h0, busy_a},   32'h1);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0042;
    tick();
    chk("wr+iss r6 busy_vec", {24'h0, busy_vec}, 32'h40);
    chk("wr+iss r6 data",     {16'h0, rd_data_a}, 32'h00000042);
    iss_en = 1'b0;
    tick();
    chk("wr r6 clears busy", {24'h0, busy_vec}, 32'h0);
    wr_en = 1'b0;
    tick();
    chk("r6 stored", {16'h0, rd_data_a}, 32'h00000042);

    // Issue and write to different registers in the same cycle.
    iss_en = 1'b1; iss_addr = 3'd5;
    tick();
    chk("iss r5", {24'h0, busy_vec}, 32'h20);
    iss_addr = 3'd1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
    tick();
    chk("iss r1 wr r5", {24'h0, busy_vec}, 32'h02);
    wr_en = 1'b0;
    tick();
    chk("re-issue busy r1", {24'h0, busy_vec}, 32'h02);
    iss_addr = 3'd0;
    tick();
    chk("issue r0 ignored", {24'h0, busy_vec}, 32'h02);

    // busy_a reflects current state; the clear lands only after the edge.
    iss_en = 1'b0; rd_addr_a = 3'd1; rd_addr_b = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hA1A1;
    #1;
    chk("busy_a no forward", {31'h0, busy_a}, 32'h1);
    tick();
    chk("busy_a after clear", {31'h0, busy_a}, 32'h0);
    chk("r1 bypass a",        {16'h0, rd_data_a}, 32'h0000A1A1);
    chk("r5 read b",          {16'h0, rd_data_b}, 32'h00005555);

    // Reset dominates write and issue.
    rst = 1'b1; iss_en = 1'b1; iss_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hABCD; rd_addr_a = 3'd4;
    tick();
    chk("rst busy_vec", {24'h0, busy_vec},  32'h0);
    chk("rst rd_data_a", {16'h0, rd_data_a}, 32'h0);
    rst = 1'b0; iss_en = 1'b0; wr_en = 1'b0;
    tick();
    chk("r4 after rst", {16'h0, rd_data_a}, 32'h0);
    chk("r5 after rst", {16'h0, rd_data_b}, 32'h0);
    chk("busy after rst", {24'h0, busy_vec}, 32'h0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_reg_file.md
SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 Parameter M, default 3, register address width.
REQ-002 Parameter W, default 16, register data width; N = 2**M registers (local constant).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  writeback enable.
REQ-006 wr_addr  input  M  writeback destination register.
REQ-007 wr_data  input  W  writeback value.
REQ-008 iss_en  input  1  issue strobe; marks the destination register busy.
REQ-009 iss_addr  input  M  destination register of the issuing instruction.
REQ-010 rd_addr_a  input  M  read port A address.
REQ-011 rd_addr_b  input  M  read port B address.
REQ-012 rd_data_a  output  W  registered read data, port A.
REQ-013 rd_data_b  output  W  registered read data, port B.
REQ-014 busy_a  output  1  combinational; busy bit of rd_addr_a.
REQ-015 busy_b  output  1  combinational; busy bit of rd_addr_b.
REQ-016 busy_vec  output  N  current busy bit of every register.

Function
REQ-017 Write: wr_addr decoded to an N-bit one-hot enable gated by wr_en; all-zero when wr_en=0.
REQ-018 On a clock edge with wr_en=1 and wr_addr!=0, register[wr_addr] takes wr_data; other registers hold.
REQ-019 Register 0 always holds 0; writes to address 0 are discarded.
REQ-020 Read latency 1 cycle: rd_data_x at cycle t+1 = register[rd_addr_x] sampled at edge t.
REQ-021 Bypass: if wr_en=1 and wr_addr==rd_addr_x!=0 at edge t, rd_data_x at t+1 = wr_data (write-first).
REQ-022 Read of address 0 returns 0 regardless of bypass.
REQ-023 Both ports independent; same address on both ports returns identical data.
REQ-024 iss_en=1 with iss_addr!=0 sets busy[iss_addr] at the edge; iss_addr=0 ignored.
REQ-025 wr_en=1 clears busy[wr_addr] at the edge.
REQ-026 Simultaneous iss_en and wr_en to same address: register written AND busy bit ends set (issue wins).
REQ-027 Simultaneous iss_en and wr_en to different addresses: both updates applied.
REQ-028 Issue to an already-busy register keeps it busy (no count, no error).
REQ-029 busy_x = busy_vec[rd_addr_x] from current state; no same-cycle forwarding of the clear.
REQ-030 busy_vec[0] is constant 0.

Reset
REQ-031 rst=1 at an edge: all registers 0, busy_vec 0, rd_data_a/rd_data_b 0.
REQ-032 rst dominates wr_en and iss_en in the same cycle; no write, no busy set.
REQ-033 First edge after rst deasserts behaves per Function with all-zero prior state.

Structure
REQ-034 Shared package holds default M, W and a busy-vector typedef sized N.
REQ-035 The one-hot write-enable decode is a sub-module, regfile_wdec (inputs addr, en; output N-bit one-hot), instantiated once.
REQ-036 Register array, busy vector and read registers live in the top module; no latches.

Verification
REQ-037 Reset then read all 8 addresses on A and B -> all rd_data 0, busy_vec 8'h00.
REQ-038 Write 16'hBEEF to r5, next cycle read A=5 -> rd_data_a 16'hBEEF one cycle later.
REQ-039 wr_en r3=16'h1234 with rd_addr_b=3 same cycle -> rd_data_b 16'h1234 next cycle (bypass).
REQ-040 Write 16'hFFFF to r0, read r0 on both ports -> 16'h0000 on both.
REQ-041 iss r6, then wr r6 16'h0042 with iss r6 same cycle -> busy_vec[6]=1, r6=16'h0042; then wr r6 alone -> busy_vec[6]=0.
REQ-042 iss r2 and wr r4 with rst=1 same cycle -> busy_vec 8'h00, r4 reads 0.
